// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game controller.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        UP,
        FLASH,
        OVER
    } state_t;

    localparam int NUM_HOLES = 5;

    // Holes are numbered 1..NUM_HOLES; anything else decodes to no mole.
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [2:0] hole);
        logic [NUM_HOLES-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_HOLES; i++) begin
            if (hole == 3'(i + 1)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mole_tick_timer.sv
// Loadable down-counter advanced by the tick enable; done marks the tick that expires it.
module mole_tick_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A load of N expires on the N-th tick after the load edge.
    assign done = tick && (count == W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: round sequencing, hit/miss judging, score and miss count.
// Optional MOLE_SPEEDUP_EN shrinks the up-window as the player scores.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int UP_TICKS    = 500,
    parameter int GAP_TICKS   = 250,
    parameter int FLASH_TICKS = 100,
    parameter int MAX_MISSES  = 5,
    parameter int SCORE_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [2:0]           hole,
    input  logic [4:0]           buttons,
    output logic [4:0]           mole,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           misses,
    output logic                 playing,
    output logic                 game_over
);

    localparam int MAX_UG  = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int MAX_DUR = (MAX_UG > FLASH_TICKS) ? MAX_UG : FLASH_TICKS;
    localparam int CNT_W   = $clog2(MAX_DUR + 1);

    state_t                 state;
    logic [NUM_HOLES-1:0]   hole_oh;
    logic [CNT_W-1:0]       up_window;
    logic [CNT_W-1:0]       load_val;
    logic [3:0]             misses_next;
    logic                   load;
    logic                   done;
    logic                   hit;
    logic                   restart;

    assign hole_oh     = hole_onehot(hole);
    assign hit         = (state == UP) && ((buttons & mole) != '0);
    assign misses_next = misses + 4'd1;
    assign restart     = start && (state == IDLE || state == OVER);

`ifdef MOLE_SPEEDUP_EN
    localparam int SHRINK = UP_TICKS / 8;
    localparam int FLOOR  = UP_TICKS / 4;

    logic [2:0]       hit_mod;
    logic [CNT_W-1:0] win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win     <= CNT_W'(UP_TICKS);
            hit_mod <= '0;
        end else if (restart) begin
            win     <= CNT_W'(UP_TICKS);
            hit_mod <= '0;
        end else if (hit) begin
            hit_mod <= hit_mod + 3'd1;
            if (hit_mod == 3'd7) begin
                if (int'(win) - SHRINK < FLOOR) win <= CNT_W'(FLOOR);
                else                            win <= win - CNT_W'(SHRINK);
            end
        end
    end

    assign up_window = win;
`else
    assign up_window = CNT_W'(UP_TICKS);
`endif

    // Timer reload is decided in the same cycle as the transition so the
    // first tick in the new state is already counted.
    always_comb begin
        load     = 1'b0;
        load_val = CNT_W'(GAP_TICKS);
        case (state)
            IDLE, OVER: load = start;
            GAP: begin
                if (done) begin
                    load     = 1'b1;
                    load_val = (hole_oh != '0) ? up_window : CNT_W'(1);
                end
            end
            UP: begin
                if (hit) begin
                    load     = 1'b1;
                    load_val = CNT_W'(FLASH_TICKS);
                end else if (done) begin
                    load = 1'b1;
                end
            end
            FLASH:   load = done;
            default: load = 1'b0;
        endcase
    end

    mole_tick_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mole      <= '0;
            score     <= '0;
            misses    <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= GAP;
                        mole      <= '0;
                        score     <= '0;
                        misses    <= '0;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                GAP: begin
                    if (done && hole_oh != '0) begin
                        mole  <= hole_oh;
                        state <= UP;
                    end
                end
                UP: begin
                    if (hit) begin
                        if (score != '1) score <= score + 1'b1;
                        state <= FLASH;
                    end else if (done) begin
                        misses <= misses_next;
                        mole   <= '0;
                        if (misses_next == 4'(MAX_MISSES)) begin
                            state     <= OVER;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                FLASH: begin
                    if (done) begin
                        mole  <= '0;
                        state <= GAP;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mole      <= '0;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed game trace plus randomized play against a behavioural model.
module tb_mole_scheduler;

    localparam int UP    = 4;
    localparam int GAPT  = 2;
    localparam int FLSH  = 1;
    localparam int MAXM  = 2;
    localparam int SW    = 3;

    localparam int P_IDLE  = 0;
    localparam int P_GAP   = 1;
    localparam int P_UP    = 2;
    localparam int P_FLASH = 3;
    localparam int P_OVER  = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          tick    = 1'b0;
    logic          start   = 1'b0;
    logic [2:0]    hole    = '0;
    logic [4:0]    buttons = '0;
    logic [4:0]    mole;
    logic [SW-1:0] score;
    logic [3:0]    misses;
    logic          playing;
    logic          game_over;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase, ticks elapsed in the phase, and the game counters.
    int         m_phase   = P_IDLE;
    int         m_elapsed = 0;
    int         m_need    = GAPT;
    logic [4:0] m_mole    = '0;
    int         m_score   = 0;
    int         m_misses  = 0;

    always #5 clk = ~clk;

    mole_scheduler #(
        .UP_TICKS    (UP),
        .GAP_TICKS   (GAPT),
        .FLASH_TICKS (FLSH),
        .MAX_MISSES  (MAXM),
        .SCORE_W     (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .start     (start),
        .hole      (hole),
        .buttons   (buttons),
        .mole      (mole),
        .score     (score),
        .misses    (misses),
        .playing   (playing),
        .game_over (game_over)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = P_IDLE; m_elapsed = 0; m_need = GAPT;
            m_mole = '0; m_score = 0; m_misses = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_OVER: begin
                    if (start) begin
                        m_phase = P_GAP; m_elapsed = 0; m_need = GAPT;
                        m_mole = '0; m_score = 0; m_misses = 0;
                    end
                end
                P_GAP: begin
                    if (tick) begin
                        m_elapsed++;
                        if (m_elapsed == m_need) begin
                            int h;
                            h = int'(hole);
                            m_elapsed = 0;
                            if (h >= 1 && h <= 5) begin
                                m_mole  = 5'(1 << (h - 1));
                                m_phase = P_UP;
                            end else begin
                                m_need = 1;
                            end
                        end
                    end
                end
                P_UP: begin
                    if ((buttons & m_mole) != 5'd0) begin
                        if (m_score < (1 << SW) - 1) m_score++;
                        m_phase = P_FLASH; m_elapsed = 0;
                    end else if (tick) begin
                        m_elapsed++;
                        if (m_elapsed == UP) begin
                            m_misses++;
                            m_mole = '0; m_elapsed = 0; m_need = GAPT;
                            m_phase = (m_misses == MAXM) ? P_OVER : P_GAP;
                        end
                    end
                end
                P_FLASH: begin
                    if (tick) begin
                        m_elapsed++;
                        if (m_elapsed == FLSH) begin
                            m_mole = '0; m_elapsed = 0; m_need = GAPT;
                            m_phase = P_GAP;
                        end
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic m_play, m_over;
        m_play = (m_phase == P_GAP || m_phase == P_UP || m_phase == P_FLASH);
        m_over = (m_phase == P_OVER);
        total++;
        if ({mole, score, misses, playing, game_over} !==
            {m_mole, SW'(m_score), 4'(m_misses), m_play, m_over}) begin
            bad++;
            $display("FAIL model_cmp t=%0t got mole=%b score=%0d misses=%0d playing=%b over=%b need mole=%b score=%0d misses=%0d playing=%b over=%b",
                     $time, mole, score, misses, playing, game_over,
                     m_mole, m_score, m_misses, m_play, m_over);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d need=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic [2:0] h, input logic [4:0] b);
        tick = t; start = s; hole = h; buttons = b;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; buttons = '0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mole", mole, 0);
        check("rst_score", score, 0);
        check("rst_playing", playing, 0);
        check("rst_over", game_over, 0);
        reset_n = 1'b1;

        step(0, 1, 0, 0);
        check("start_playing", playing, 1);
        step(1, 0, 3, 0);
        check("gap_first_tick_dark", mole, 0);
        step(1, 0, 3, 0);
        check("hole3_lit", mole, 5'b00100);
        check("hole3_score", score, 0);
        step(0, 1, 0, 0);
        check("start_ignored_up", mole, 5'b00100);
        step(0, 0, 0, 5'b00100);
        check("hit_score", score, 1);
        check("flash_mole_held", mole, 5'b00100);
        step(0, 0, 0, 5'b00100);
        check("flash_btn_ignored", score, 1);
        step(1, 0, 0, 0);
        check("flash_end_dark", mole, 0);
        check("flash_end_playing", playing, 1);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("hole0_stays_dark", mole, 0);
        step(1, 0, 5, 0);
        check("hole5_lit", mole, 5'b10000);
        step(0, 0, 0, 5'b00001);
        check("wrong_btn_score", score, 1);
        check("wrong_btn_mole", mole, 5'b10000);
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 0, 5'b10000);
        check("tie_hit_score", score, 2);
        check("tie_no_miss", misses, 0);
        step(1, 0, 0, 0);

        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check("hole1_lit", mole, 5'b00001);
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 0, 5'b00010);
        check("miss1_count", misses, 1);
        check("miss1_mole", mole, 0);
        check("miss1_score", score, 2);
        check("miss1_playing", playing, 1);

        step(1, 0, 2, 0);
        step(1, 0, 2, 0);
        check("hole2_lit", mole, 5'b00010);
        repeat (4) step(1, 0, 0, 0);
        check("miss2_count", misses, 2);
        check("miss2_over", game_over, 1);
        check("miss2_playing", playing, 0);
        check("miss2_mole", mole, 0);
        step(1, 0, 3, 5'b00100);
        check("over_holds_score", score, 2);

        step(0, 1, 0, 0);
        check("restart_score", score, 0);
        check("restart_misses", misses, 0);
        check("restart_over", game_over, 0);
        step(1, 0, 4, 0);
        step(1, 0, 4, 0);
        check("hole4_lit", mole, 5'b01000);
        step(1, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_mole", mole, 0);
        check("async_rst_playing", playing, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) step(1, 0, 3, 0);
        check("no_resume_playing", playing, 0);
        check("no_resume_mole", mole, 0);
        step(0, 1, 0, 0);
        check("resume_playing", playing, 1);

        for (int i = 0; i < 4000; i++) begin
            logic       t, s;
            logic [4:0] b;
            int         r;
            t = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 9);
            if (r < 2)       b = m_mole | 5'($urandom_range(0, 31));
            else if (r == 2) b = 5'($urandom_range(0, 31));
            else if (r == 3) b = m_mole;
            else             b = '0;
            step(t, s, 3'($urandom_range(0, 7)), b);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game controller for the whack-a-mole datapath. It samples the pseudorandom hole number (1..5) at the start of each round and lights that mole for a bounded window. It judges button presses as hits or misses, keeps score and miss count, and ends the game after a configurable number of misses. It sits between the random hole generator, the debounced button inputs and the LED/score display logic.

## Interface
Parameters:
- UP_TICKS, 500: ticks a mole stays up (window length).
- GAP_TICKS, 250: ticks of dark time between moles.
- FLASH_TICKS, 100: ticks the hit mole stays lit after a hit.
- MAX_MISSES, 5: misses that end the game, 1..15.
- SCORE_W, 8: score width.

Ports (clock and reset first):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase enable (1 ms); all durations count tick pulses.
- start  in  1  one-cycle pulse; starts or restarts the game.
- hole  in  3  hole number from the random generator; legal values 1..5.
- buttons  in  5  one-cycle debounced press pulses; bit i = hole i+1.
- mole  out  5  one-hot lit mole; 0 when no mole is lit.
- score  out  SCORE_W  hit count, saturating.
- misses  out  4  miss count.
- playing  out  1  high in GAP, UP and FLASH.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, GAP, UP, FLASH, OVER. Reset enters IDLE.
- Reset values: mole=0, score=0, misses=0, playing=0, game_over=0, tick counter=0.
- IDLE: start clears score, misses and the tick counter, then goes to GAP.
- GAP: count GAP_TICKS ticks. On the terminal tick, sample hole.
  - hole in 1..5: latch bit hole-1 into mole, clear the counter, go to UP.
  - hole 0, 6 or 7: stay in GAP and resample on the next tick.
- UP: any cycle with buttons & mole nonzero is a hit.
  - score increments, saturating at 2^SCORE_W-1.
  - Go to FLASH with mole held.
  - Extra wrong bits set in the same cycle are ignored.
- UP: buttons with no bit matching mole are ignored.
- UP timeout: when UP_TICKS ticks elapse without a hit, the round is a miss.
  - misses increments, mole clears.
  - If the new misses equals MAX_MISSES, go to OVER; otherwise go to GAP.
- Simultaneous hit and timeout in the same cycle: the hit wins and no miss is counted.
- FLASH: after FLASH_TICKS ticks, mole clears and the FSM goes to GAP. Buttons are ignored.
- OVER: mole=0. score and misses hold. start behaves as in IDLE.
- start in GAP, UP or FLASH is ignored.
- Arithmetic: the tick counter is wide enough for max(UP_TICKS, GAP_TICKS, FLASH_TICKS). A duration of N ticks expires on the N-th tick pulse after state entry.

## Timing
- All outputs are registered and update on the clk edge that performs the state transition.
- Hit-to-score latency: 1 cycle. score and the FLASH state are visible the cycle after the button pulse.
- The hole sample uses the hole value present in the cycle of the terminal GAP tick. mole is valid the next cycle.
- Asynchronous reset at any point returns immediately to IDLE with all outputs at reset values. The game does not resume.
- A tick and a button in the same cycle are both processed. The hit takes priority over the counter expiry.

## Configuration
- MOLE_SPEEDUP_EN defined:
  - The effective up-window starts at UP_TICKS.
  - After every 8th hit, the window shrinks by UP_TICKS/8.
  - The window never goes below UP_TICKS/4.
  - The window resets to UP_TICKS on start.
- MOLE_SPEEDUP_EN undefined: the up-window is always UP_TICKS and no shrink logic is built.

## Structure
- Shared package mole_pkg holds:
  - the state enum (IDLE, GAP, UP, FLASH, OVER);
  - the NUM_HOLES=5 constant;
  - a hole-to-one-hot decode function that returns 0 for illegal hole values.
- One sub-module, mole_tick_timer: a loadable down-counter on tick with a done pulse. It is reused for the GAP, UP and FLASH durations.

## Test plan
- Use small parameters: UP=4, GAP=2, FLASH=1, MAX_MISSES=2.
- Reset, start, hole=3 -> after 2 ticks mole=5'b00100, playing=1, score=0.
- In UP, press buttons=5'b00100 -> next cycle score=1, mole held for 1 tick, then mole=0 in GAP.
- In UP, press 5'b00001 only, then let 4 ticks pass -> misses=1, score unchanged, back to GAP. A second timeout -> misses=2, game_over=1, mole=0.
- hole=0 at the GAP expiry, then hole=5 -> the mole stays dark for one extra tick, then mole=5'b10000.
- Correct press and the 4th UP tick in the same cycle -> score+1, misses unchanged.
- Drive reset_n low mid-UP, then release -> IDLE, all outputs 0, and start is required to resume.
